// File: rtl/gamma_cycle_sequencer_if.sv
// gamma_cycle_sequencer_if: request/result handshake bundle
// between the control plane and the gamma-cycle sequencer.
interface gamma_cycle_sequencer_if #(
  parameter int TW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_a;
  logic [TW-1:0] req_b;
  logic          res_valid;
  logic          res_ready;
  logic [TW-1:0] res_time;
  logic          res_fired;
  logic          res_glitch;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_time,
    input  res_fired,
    input  res_glitch
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_time,
    output res_fired,
    output res_glitch
  );
endinterface

// File: rtl/gamma_cycle_sequencer.sv
// gamma_cycle_sequencer: runs one race-logic comparison per
// gamma cycle and decodes the comparator edge time.
module gamma_cycle_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int TW = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                    aclk,
  input  logic                    rst,
  gamma_cycle_sequencer_if.slave  bus,
  output logic                    grst,
  output logic                    a_out,
  output logic                    b_out,
  input  logic                    q_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRST,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [TW-1:0] LAST_T = TW'(GAMMA_CYCLE_WIDTH - 2);
  localparam logic [TW-1:0] NO_T   = '1;

  state_e        state_q, state_d;
  logic [TW-1:0] a_q, b_q;
  logic [TW-1:0] t_q, t_nx;
  logic          a_out_q, b_out_q;
  logic [TW-1:0] time_q;
  logic          fired_q;
  logic          glitch_q;
  logic          accept;

  assign t_nx   = t_q + TW'(1);
  assign accept = bus.req_ready & bus.req_valid;

  always_ff @(posedge aclk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.req_valid) state_d = S_GRST;
      S_GRST: state_d = S_RUN;
      S_RUN:  if (t_q == LAST_T) state_d = S_DONE;
      S_DONE: begin
        if (bus.res_ready)
          state_d = bus.req_valid ? S_GRST : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // req_ready is the only output with a combinational input path
  always_comb begin
    grst           = (state_q == S_IDLE) | (state_q == S_GRST);
    bus.res_valid  = (state_q == S_DONE);
    bus.req_ready  = ~rst & ((state_q == S_IDLE) |
                     ((state_q == S_DONE) & bus.res_ready));
    bus.res_time   = time_q;
    bus.res_fired  = fired_q;
    bus.res_glitch = glitch_q;
    a_out          = a_out_q;
    b_out          = b_out_q;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      a_out_q  <= 1'b0;
      b_out_q  <= 1'b0;
      time_q   <= NO_T;
      fired_q  <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.req_a;
        b_q     <= bus.req_b;
        a_out_q <= 1'b0;
        b_out_q <= 1'b0;
      end
      unique case (state_q)
        S_GRST: begin
          time_q   <= NO_T;
          fired_q  <= 1'b0;
          glitch_q <= q_in;
          t_q      <= '0;
          a_out_q  <= (a_q == '0);
          b_out_q  <= (b_q == '0);
        end
        S_RUN: begin
          if (q_in && !fired_q) begin
            time_q  <= t_q;
            fired_q <= 1'b1;
          end
          // t never reaches all-ones, so "no spike" never rises
          if (t_q != LAST_T) begin
            t_q     <= t_nx;
            a_out_q <= (a_q <= t_nx);
            b_out_q <= (b_q <= t_nx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// tb_gamma_cycle_sequencer: directed scoreboard bench with a
// max comparator (q = a_out & b_out) and W = 16.
module tb_gamma_cycle_sequencer;

  localparam int W  = 16;
  localparam int TW = 4;

  typedef struct packed {
    logic [TW-1:0] t;
    logic          f;
    logic          g;
  } exp_s;

  logic aclk = 1'b0;
  logic rst;
  logic grst, a_out, b_out, q_in;
  logic force_q;
  bit   glitch_plan;
  bit   bb_win;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_res    = 0;
  int   cyc      = 0;
  int   grst_cnt = 0;
  int   idle_cnt = 0;
  exp_s sb[$];
  int   res_cyc[$];

  gamma_cycle_sequencer_if #(.TW(TW)) bus ();

  gamma_cycle_sequencer #(
    .GAMMA_CYCLE_WIDTH(W)
  ) dut (
    .aclk (aclk),
    .rst  (rst),
    .bus  (bus),
    .grst (grst),
    .a_out(a_out),
    .b_out(b_out),
    .q_in (q_in)
  );

  assign q_in = (a_out & b_out) | force_q;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_s model(input logic [TW-1:0] a,
                                 input logic [TW-1:0] b,
                                 input bit g);
    exp_s e;
    if (a == '1 || b == '1) begin
      e.t = '1;
      e.f = 1'b0;
    end else begin
      e.t = (a > b) ? a : b;
      e.f = 1'b1;
    end
    e.g = g;
    return e;
  endfunction

  always @(negedge aclk) begin
    exp_s e;
    if (bus.res_valid && bus.res_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_time", bus.res_time, e.t);
        chk("res_fired", bus.res_fired, e.f);
        chk("res_glitch", bus.res_glitch, e.g);
        res_cyc.push_back(cyc);
        n_res++;
      end
    end
    if (!rst && bus.req_valid && bus.req_ready)
      sb.push_back(model(bus.req_a, bus.req_b, glitch_plan));
    if (bb_win) begin
      if (grst) grst_cnt++;
      if (bus.req_ready && !bus.res_valid) idle_cnt++;
    end
  end

  task automatic offer(input logic [TW-1:0] a,
                       input logic [TW-1:0] b, input bit g);
    bit ok = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    glitch_plan   = g;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
    end
    chk("accept_in_time", 32'(ok), 1);
    @(posedge aclk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_result();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.res_valid) begin
        ok = 1;
        break;
      end
    end
    chk("result_in_time", 32'(ok), 1);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    bit seen;
    rst           = 1'b1;
    force_q       = 1'b0;
    glitch_plan   = 0;
    bb_win        = 0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_outs", {grst, a_out, b_out, bus.res_valid,
        bus.req_ready}, 5'b10000);
    chk("rst_res", {bus.res_time, bus.res_fired, bus.res_glitch},
        6'b111100);
    step();
    rst = 1'b0;
    @(negedge aclk);
    chk("ready_after_rst", bus.req_ready, 1);
    step();

    // a=2, b=4: cycle-accurate waveform from E+1 to E+17
    offer(4'd2, 4'd4, 0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge aclk);
      chk($sformatf("wave_c%0d", c),
          {grst, a_out, b_out, bus.res_valid},
          {c == 1, c >= 4, c >= 6, c == 17});
    end
    step();

    offer(4'd9, 4'd3, 0);  wait_result(); step();
    offer(4'd0, 4'd0, 0);  wait_result(); step();
    offer(4'd14, 4'd14, 0); wait_result(); step();
    offer(4'd15, 4'd5, 0); wait_result();
    chk("nospike_outs", {a_out, b_out}, 2'b01);
    step();

    // back-to-back jobs with both handshakes held high
    res_cyc.delete();
    offer(4'd1, 4'd2, 0);
    bb_win = 1;
    bus.req_valid = 1'b1;
    bus.req_a = 4'd7;
    bus.req_b = 4'd7;
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge aclk);
        if (bus.req_ready) begin
          seen = 1;
          break;
        end
      end
      chk("bb_accept", 32'(seen), 1);
      step();
      bus.req_a = 4'd12;
      bus.req_b = 4'd0;
      if (k == 1) bus.req_valid = 1'b0;
    end
    wait_result();
    step();
    bb_win = 0;
    chk("bb_count", 32'(res_cyc.size()), 3);
    if (res_cyc.size() == 3) begin
      chk("bb_gap1", 32'(res_cyc[1] - res_cyc[0]), 17);
      chk("bb_gap2", 32'(res_cyc[2] - res_cyc[1]), 17);
    end
    chk("bb_grst", 32'(grst_cnt), 3);
    chk("bb_idle", 32'(idle_cnt), 0);

    // glitch: q_in forced high throughout the GRST cycle
    offer(4'd3, 4'd7, 1);
    force_q = 1'b1;
    step();
    force_q = 1'b0;
    wait_result();
    step();

    // consumer stalls 10 cycles in DONE
    bus.res_ready = 1'b0;
    offer(4'd5, 4'd6, 0);
    wait_result();
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge aclk);
      chk($sformatf("hold_%0d", i),
          {bus.res_valid, bus.res_time, bus.res_fired,
           bus.req_ready, a_out, b_out, grst},
          {1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    bus.res_ready = 1'b1;
    step();

    // reset during run cycle t=5 drops the job
    offer(4'd3, 4'd4, 0);
    repeat (6) step();
    @(negedge aclk);
    chk("pre_abort_outs", {grst, a_out, b_out}, 3'b011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge aclk);
    chk("abort_outs", {grst, a_out, b_out, bus.res_valid,
        bus.req_ready}, 5'b10001);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge aclk);
      if (bus.res_valid) seen = 1;
    end
    chk("abort_no_result", 32'(seen), 0);
    chk("abort_sb", 32'(sb.size()), 1);
    sb.delete();

    chk("results_total", 32'(n_res), 10);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gamma_cycle_sequencer.md
# gamma_cycle_sequencer

Sequences one temporal comparison per gamma cycle around a race-logic comparator such as `greater_than_eq`. It accepts integer operand pairs through a valid/ready request port and encodes each operand as an edge time on `a_out`/`b_out`. It generates the gamma-cycle reset `grst`, samples the comparator's `q` to decode its edge time, and returns the decoded time through a valid/ready result port. It sits between the digital control plane and the temporal datapath.

## Interface

Parameters:
- `GAMMA_CYCLE_WIDTH`, default 16: cycles per gamma cycle (1 grst cycle plus `GAMMA_CYCLE_WIDTH-1` run cycles). Must be a power of two and at least 4.
- `TW`, default `$clog2(GAMMA_CYCLE_WIDTH)`: width of operand and time fields.

Ports:
- `aclk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  operand pair offered.
- `req_ready`  out  1  sequencer accepts the pair.
- `req_a`  in  TW  edge time for `a_out`; all-ones means no spike.
- `req_b`  in  TW  edge time for `b_out`; all-ones means no spike.
- `grst`  out  1  gamma reset to the comparator.
- `a_out`  out  1  encoded operand a, registered.
- `b_out`  out  1  encoded operand b, registered.
- `q_in`  in  1  comparator output.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_time`  out  TW  first run-cycle index at which `q_in` was sampled high; all-ones if `q_in` never went high.
- `res_fired`  out  1  `q_in` went high during the run.
- `res_glitch`  out  1  `q_in` was high during the GRST cycle.

## Operation

FSM states: IDLE, GRST, RUN, DONE.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `req_a`/`req_b` and go to GRST.
- **GRST** (1 cycle)
  - `grst`=1 and `a_out`=`b_out`=0.
  - Clear the capture registers: time = all-ones, fired = 0.
  - Sample `q_in`; if it is high, set glitch.
  - Go to RUN with t=0.
- **RUN** (`GAMMA_CYCLE_WIDTH-1` cycles, t = 0 .. `GAMMA_CYCLE_WIDTH-2`)
  - `a_out` is high during cycle t iff `req_a` ≤ t. Same rule for `b_out` with `req_b`.
  - Encoding: an operand equal to all-ones never rises. An operand equal to 0 is high for the whole run.
  - `q_in` is sampled at the end of each RUN cycle. On the first high sample with fired=0: time←t, fired←1. Later samples are ignored.
  - After t=`GAMMA_CYCLE_WIDTH-2`, go to DONE.
- **DONE**
  - `res_valid`=1. `res_*` are stable until the handshake completes.
  - `a_out`/`b_out` hold their last values and `grst`=0, so the comparator state is held.
  - On `res_ready`: if `req_valid` is also high, accept the new pair and go directly to GRST. Otherwise go to IDLE.
- **Ready logic:** `req_ready` = IDLE, or (DONE and `res_ready`). It is combinational from state and `res_ready`. No other output depends combinationally on an input.
- **`grst` level by state:** 1 in IDLE and GRST; 0 in RUN and DONE. The comparator is therefore held reset while idle.
- **Reset:**
  - `rst` high at a clock edge forces IDLE from any state, including mid-RUN.
  - An aborted job produces no result and is dropped silently.
  - Register values after reset: `grst`=1, `a_out`=0, `b_out`=0, `res_valid`=0, `res_time`=all-ones, `res_fired`=0, `res_glitch`=0.
  - `req_ready` reads 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
- **Width rules:**
  - t is a TW-bit counter and never reaches all-ones, so "no spike" can never compare ≤ t.
  - `res_time` ≤ `GAMMA_CYCLE_WIDTH-2` whenever `res_fired`=1.

## Timing

- Request accepted at edge E. GRST occupies cycle E+1, and run cycle t occupies cycle E+2+t.
- `res_valid` is first high in cycle E+1+`GAMMA_CYCLE_WIDTH` (E+17 for the default).
- Sustained throughput is one pair per `GAMMA_CYCLE_WIDTH+1` cycles when `res_ready` and `req_valid` are held high.
- `a_out`/`b_out` change only at GRST entry and at RUN cycle boundaries.
- The comparator is expected to be combinational or same-cycle. A comparator edge appearing in cycle t is recorded as t.
- Simultaneous `res_ready` and `req_valid` in DONE give no bubble: the next cycle is GRST.

## Test plan

Bench comparator model: `q_in` = `a_out` & `b_out` (max), with `GAMMA_CYCLE_WIDTH`=16.

- a=2, b=4 → `a_out` rises in cycle E+4 and `b_out` in E+6; result `res_time`=4, `res_fired`=1, `res_glitch`=0, `res_valid` at E+17.
- a=9, b=3 → `res_time`=9. Then a=0, b=0 → `res_time`=0. Then a=14, b=14 → `res_time`=14.
- a=15, b=5 → `b_out` rises but `a_out` never does; result `res_time`=15, `res_fired`=0.
- Back-to-back: `res_ready` and `req_valid` held high with three pairs → results every 17 cycles, no IDLE cycle, `grst` pulses once per job.
- Hold `res_ready` low for 10 cycles in DONE → `res_*` stable, `req_ready`=0, `a_out`/`b_out` held.
- Force `q_in`=1 during GRST → `res_glitch`=1.
- Assert `rst` at run cycle t=5 → next cycle IDLE, `grst`=1, `a_out`=`b_out`=0, no `res_valid` ever for that job.
